// File: rtl/qtable_neighbor_engine_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qtable_neighbor_engine_pkg : shared codes and types for the Q-table engine
// Rev 1.0
// ----------------------------------------------------------------------------
package qtable_neighbor_engine_pkg;

  localparam logic [2:0] PKT_HELLO  = 3'b001;
  localparam logic [2:0] PKT_CH_ADV = 3'b010;
  localparam logic [2:0] PKT_JOIN   = 3'b011;
  localparam logic [2:0] PKT_ACK    = 3'b100;
  localparam logic [2:0] PKT_DATA   = 3'b101;

  typedef enum logic [1:0] {
    RES_UPDATED  = 2'd0,
    RES_INSERTED = 2'd1,
    RES_REPLACED = 2'd2,
    RES_DROPPED  = 2'd3
  } result_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NBR_SCAN = 3'd1,
    ST_NBR_WR   = 3'd2,
    ST_CH_SCAN  = 3'd3,
    ST_CH_WR    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Index width for a table; a one-entry table still needs a 1-bit address.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qtable_neighbor_engine_table_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qtable_neighbor_engine_table_scanner : sequential key search over a 1-cycle RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module qtable_neighbor_engine_table_scanner
  import qtable_neighbor_engine_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter bit TRACK_MIN  = 1'b1,
  localparam int AW = idx_width(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CW-1:0]         len_i,
  input  logic [WORD_WIDTH-1:0] key_i,
  output logic [AW-1:0]         rd_addr_o,
  input  logic [WORD_WIDTH-1:0] rd_id_i,
  input  logic [WORD_WIDTH-1:0] rd_q_i,
  output logic                  hit_o,
  output logic                  last_o,
  output logic [AW-1:0]         hit_idx_o,
  output logic [AW-1:0]         min_idx_o,
  output logic [WORD_WIDTH-1:0] min_val_o
);

  logic          issue_q;
  logic [CW-1:0] addr_q;
  logic          chk_q;
  logic [CW-1:0] chk_idx_q;
  logic [CW-1:0] final_idx;

  // Data returned this cycle belongs to the address issued last cycle (chk_idx_q).
  assign final_idx = len_i - CW'(1);
  assign hit_o     = chk_q && (rd_id_i == key_i);
  assign last_o    = chk_q && (chk_idx_q == final_idx);
  assign hit_idx_o = chk_idx_q[AW-1:0];
  assign rd_addr_o = addr_q[AW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_q   <= 1'b0;
      addr_q    <= '0;
      chk_q     <= 1'b0;
      chk_idx_q <= '0;
    end else if (start_i) begin
      issue_q <= 1'b1;
      addr_q  <= '0;
      chk_q   <= 1'b0;
    end else if (hit_o || last_o) begin
      issue_q <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      chk_q     <= issue_q;
      chk_idx_q <= addr_q;
      if (issue_q) begin
        if (addr_q == final_idx) begin
          issue_q <= 1'b0;
        end else begin
          addr_q <= addr_q + CW'(1);
        end
      end
    end
  end

  generate
    if (TRACK_MIN) begin : g_min_track
      logic                  min_ok_q;
      logic [WORD_WIDTH-1:0] min_val_q;
      logic [AW-1:0]         min_idx_q;
      logic                  take;

      // Strict less-than keeps the earliest index on equal Q values.
      assign take      = !min_ok_q || (rd_q_i < min_val_q);
      assign min_val_o = take ? rd_q_i : min_val_q;
      assign min_idx_o = take ? chk_idx_q[AW-1:0] : min_idx_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          min_ok_q  <= 1'b0;
          min_val_q <= '0;
          min_idx_q <= '0;
        end else if (start_i) begin
          min_ok_q <= 1'b0;
        end else if (chk_q) begin
          min_ok_q  <= 1'b1;
          min_val_q <= min_val_o;
          min_idx_q <= min_idx_o;
        end
      end
    end else begin : g_no_min
      logic unused_rd_q;
      assign unused_rd_q = ^rd_q_i;
      assign min_val_o   = '0;
      assign min_idx_o   = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/qtable_neighbor_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qtable_neighbor_engine : per-packet neighbour / cluster-head table update engine
// Rev 1.0
// ----------------------------------------------------------------------------
module qtable_neighbor_engine
  import qtable_neighbor_engine_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_NBR    = 32,
  parameter int MAX_CH     = 8,
  parameter bit REPLACE_EN = 1'b1,
  localparam int NAW = idx_width(MAX_NBR),
  localparam int CAW = idx_width(MAX_CH),
  localparam int NCW = $clog2(MAX_NBR + 1),
  localparam int CCW = $clog2(MAX_CH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [WORD_WIDTH-1:0] f_src_id_i,
  input  logic [WORD_WIDTH-1:0] f_src_hops_i,
  input  logic [WORD_WIDTH-1:0] f_cluster_id_i,
  input  logic [WORD_WIDTH-1:0] f_energy_i,
  input  logic [WORD_WIDTH-1:0] f_qvalue_i,
  input  logic [WORD_WIDTH-1:0] f_known_ch_i,
  input  logic [2:0]            f_pkt_type_i,
  output logic [NAW-1:0]        nbr_rd_addr_o,
  input  logic [WORD_WIDTH-1:0] nbr_rd_id_i,
  input  logic [WORD_WIDTH-1:0] nbr_rd_q_i,
  output logic                  nbr_wr_en_o,
  output logic [NAW-1:0]        nbr_wr_addr_o,
  output logic [WORD_WIDTH-1:0] nbr_wr_id_o,
  output logic [WORD_WIDTH-1:0] nbr_wr_hops_o,
  output logic [WORD_WIDTH-1:0] nbr_wr_cluster_o,
  output logic [WORD_WIDTH-1:0] nbr_wr_energy_o,
  output logic [WORD_WIDTH-1:0] nbr_wr_q_o,
  output logic [CAW-1:0]        ch_rd_addr_o,
  input  logic [WORD_WIDTH-1:0] ch_rd_data_i,
  output logic                  ch_wr_en_o,
  output logic [CAW-1:0]        ch_wr_addr_o,
  output logic [WORD_WIDTH-1:0] ch_wr_data_o,
  output logic [NCW-1:0]        neighbor_count_o,
  output logic [CCW-1:0]        known_ch_count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            result_o
);

  state_t                state_q;
  result_t               result_q;
  result_t               pend_res_q;
  logic [WORD_WIDTH-1:0] id_q, hops_q, cl_q, energy_q, qv_q, kch_q;
  logic [NCW-1:0]        ncnt_q;
  logic [CCW-1:0]        ccnt_q;
  logic                  nwr_en_q, cwr_en_q, busy_q, done_q;
  logic [NAW-1:0]        nwr_addr_q;
  logic [CAW-1:0]        cwr_addr_q;

  logic                  nbr_start, nbr_hit, nbr_last;
  logic [NAW-1:0]        nbr_hit_idx, nbr_min_idx;
  logic [WORD_WIDTH-1:0] nbr_min_val;
  logic                  ch_start, ch_hit, ch_last, ch_needed;
  logic [CAW-1:0]        ch_hit_idx_unused, ch_min_idx_unused;
  logic [WORD_WIDTH-1:0] ch_min_val_unused;
  logic                  nbr_full, ch_full;
  logic                  unused_pkt_type;

  assign unused_pkt_type = ^f_pkt_type_i;

  assign nbr_full  = (ncnt_q == NCW'(MAX_NBR));
  assign ch_full   = (ccnt_q == CCW'(MAX_CH));
  assign ch_needed = (id_q != '0) && (kch_q != '0);
  assign nbr_start = (state_q == ST_IDLE) && en_i && !clr_i &&
                     (f_src_id_i != '0) && (ncnt_q != '0);
  assign ch_start  = (state_q == ST_NBR_WR) && ch_needed && (ccnt_q != '0);

  qtable_neighbor_engine_table_scanner #(
    .WORD_WIDTH(WORD_WIDTH), .DEPTH(MAX_NBR), .TRACK_MIN(1'b1)
  ) u_nbr_scan (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (nbr_start),
    .len_i     (ncnt_q),
    .key_i     (id_q),
    .rd_addr_o (nbr_rd_addr_o),
    .rd_id_i   (nbr_rd_id_i),
    .rd_q_i    (nbr_rd_q_i),
    .hit_o     (nbr_hit),
    .last_o    (nbr_last),
    .hit_idx_o (nbr_hit_idx),
    .min_idx_o (nbr_min_idx),
    .min_val_o (nbr_min_val)
  );

  qtable_neighbor_engine_table_scanner #(
    .WORD_WIDTH(WORD_WIDTH), .DEPTH(MAX_CH), .TRACK_MIN(1'b0)
  ) u_ch_scan (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (ch_start),
    .len_i     (ccnt_q),
    .key_i     (kch_q),
    .rd_addr_o (ch_rd_addr_o),
    .rd_id_i   (ch_rd_data_i),
    .rd_q_i    ('0),
    .hit_o     (ch_hit),
    .last_o    (ch_last),
    .hit_idx_o (ch_hit_idx_unused),
    .min_idx_o (ch_min_idx_unused),
    .min_val_o (ch_min_val_unused)
  );

  // Empty tables skip their scan state so the first write issues the cycle after en.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      result_q   <= RES_UPDATED;
      pend_res_q <= RES_UPDATED;
      id_q       <= '0;
      hops_q     <= '0;
      cl_q       <= '0;
      energy_q   <= '0;
      qv_q       <= '0;
      kch_q      <= '0;
      ncnt_q     <= '0;
      ccnt_q     <= '0;
      nwr_en_q   <= 1'b0;
      nwr_addr_q <= '0;
      cwr_en_q   <= 1'b0;
      cwr_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      nwr_en_q <= 1'b0;
      cwr_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_i) begin
            ncnt_q <= '0;
            ccnt_q <= '0;
          end else if (en_i) begin
            id_q     <= f_src_id_i;
            hops_q   <= f_src_hops_i;
            cl_q     <= f_cluster_id_i;
            energy_q <= f_energy_i;
            qv_q     <= f_qvalue_i;
            kch_q    <= f_known_ch_i;
            busy_q   <= 1'b1;
            if (f_src_id_i == '0) begin
              pend_res_q <= RES_DROPPED;
              state_q    <= ST_NBR_WR;
            end else if (ncnt_q == '0) begin
              nwr_en_q   <= 1'b1;
              nwr_addr_q <= '0;
              ncnt_q     <= NCW'(1);
              pend_res_q <= RES_INSERTED;
              state_q    <= ST_NBR_WR;
            end else begin
              state_q <= ST_NBR_SCAN;
            end
          end
        end
        ST_NBR_SCAN: begin
          if (nbr_hit) begin
            nwr_en_q   <= 1'b1;
            nwr_addr_q <= nbr_hit_idx;
            pend_res_q <= RES_UPDATED;
            state_q    <= ST_NBR_WR;
          end else if (nbr_last) begin
            state_q <= ST_NBR_WR;
            if (!nbr_full) begin
              nwr_en_q   <= 1'b1;
              nwr_addr_q <= ncnt_q[NAW-1:0];
              ncnt_q     <= ncnt_q + NCW'(1);
              pend_res_q <= RES_INSERTED;
            end else if (REPLACE_EN && (qv_q > nbr_min_val)) begin
              nwr_en_q   <= 1'b1;
              nwr_addr_q <= nbr_min_idx;
              pend_res_q <= RES_REPLACED;
            end else begin
              pend_res_q <= RES_DROPPED;
            end
          end
        end
        ST_NBR_WR: begin
          if (!ch_needed) begin
            done_q   <= 1'b1;
            result_q <= pend_res_q;
            state_q  <= ST_DONE;
          end else if (ccnt_q == '0) begin
            cwr_en_q   <= 1'b1;
            cwr_addr_q <= '0;
            ccnt_q     <= CCW'(1);
            state_q    <= ST_CH_WR;
          end else begin
            state_q <= ST_CH_SCAN;
          end
        end
        ST_CH_SCAN: begin
          if (ch_hit) begin
            state_q <= ST_CH_WR;
          end else if (ch_last) begin
            state_q <= ST_CH_WR;
            if (!ch_full) begin
              cwr_en_q   <= 1'b1;
              cwr_addr_q <= ccnt_q[CAW-1:0];
              ccnt_q     <= ccnt_q + CCW'(1);
            end
          end
        end
        ST_CH_WR: begin
          done_q   <= 1'b1;
          result_q <= pend_res_q;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign nbr_wr_en_o      = nwr_en_q;
  assign nbr_wr_addr_o    = nwr_addr_q;
  assign nbr_wr_id_o      = id_q;
  assign nbr_wr_hops_o    = hops_q;
  assign nbr_wr_cluster_o = cl_q;
  assign nbr_wr_energy_o  = energy_q;
  assign nbr_wr_q_o       = qv_q;
  assign ch_wr_en_o       = cwr_en_q;
  assign ch_wr_addr_o     = cwr_addr_q;
  assign ch_wr_data_o     = kch_q;
  assign neighbor_count_o = ncnt_q;
  assign known_ch_count_o = ccnt_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign result_o         = result_q;

endmodule
`default_nettype wire

// File: tb/tb_qtable_neighbor_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qtable_neighbor_engine : directed + random bench against a table-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_qtable_neighbor_engine;

  localparam int W  = 16;
  localparam int MN = 4;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr;
  logic [W-1:0]  f_src_id, f_src_hops, f_cluster_id, f_energy, f_qvalue, f_known_ch;
  logic [2:0]    f_pkt_type;
  logic [1:0]    nbr_rd_addr, nbr_wr_addr, ch_rd_addr, ch_wr_addr;
  logic [W-1:0]  nbr_rd_id, nbr_rd_q, ch_rd_data;
  logic          nbr_wr_en, ch_wr_en;
  logic [W-1:0]  nbr_wr_id, nbr_wr_hops, nbr_wr_cluster, nbr_wr_energy, nbr_wr_q, ch_wr_data;
  logic [2:0]    neighbor_count, known_ch_count;
  logic          busy, done;
  logic [1:0]    result;

  always #5 clk = ~clk;

  qtable_neighbor_engine #(
    .WORD_WIDTH(W), .MAX_NBR(MN), .MAX_CH(MC), .REPLACE_EN(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr),
    .f_src_id_i(f_src_id), .f_src_hops_i(f_src_hops), .f_cluster_id_i(f_cluster_id),
    .f_energy_i(f_energy), .f_qvalue_i(f_qvalue), .f_known_ch_i(f_known_ch),
    .f_pkt_type_i(f_pkt_type),
    .nbr_rd_addr_o(nbr_rd_addr), .nbr_rd_id_i(nbr_rd_id), .nbr_rd_q_i(nbr_rd_q),
    .nbr_wr_en_o(nbr_wr_en), .nbr_wr_addr_o(nbr_wr_addr), .nbr_wr_id_o(nbr_wr_id),
    .nbr_wr_hops_o(nbr_wr_hops), .nbr_wr_cluster_o(nbr_wr_cluster),
    .nbr_wr_energy_o(nbr_wr_energy), .nbr_wr_q_o(nbr_wr_q),
    .ch_rd_addr_o(ch_rd_addr), .ch_rd_data_i(ch_rd_data),
    .ch_wr_en_o(ch_wr_en), .ch_wr_addr_o(ch_wr_addr), .ch_wr_data_o(ch_wr_data),
    .neighbor_count_o(neighbor_count), .known_ch_count_o(known_ch_count),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  // External tables: registered one-cycle read, write on strobe.
  logic [W-1:0] mem_id [MN];
  logic [W-1:0] mem_q  [MN];
  logic [W-1:0] mem_ch [MC];
  always @(posedge clk) begin
    if (nbr_wr_en) begin
      mem_id[nbr_wr_addr] <= nbr_wr_id;
      mem_q[nbr_wr_addr]  <= nbr_wr_q;
    end
    if (ch_wr_en) mem_ch[ch_wr_addr] <= ch_wr_data;
    nbr_rd_id  <= mem_id[nbr_rd_addr];
    nbr_rd_q   <= mem_q[nbr_rd_addr];
    ch_rd_data <= mem_ch[ch_rd_addr];
  end

  // Reference model: table contents and counts as the node should see them.
  int           m_ncnt, m_ccnt;
  logic [W-1:0] m_id [MN];
  logic [W-1:0] m_q  [MN];
  logic [W-1:0] m_ch [MC];
  int           total = 0;
  int           bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pkt(input logic [W-1:0] id, input logic [W-1:0] hops,
                         input logic [W-1:0] cl, input logic [W-1:0] e,
                         input logic [W-1:0] q, input logic [W-1:0] ch,
                         input bit poke, input int exp_lat,
                         output int nw_j, output int cw_j);
    int exp_res, exp_naddr, exp_caddr, n0, m0, found, mi, lat, nw_cnt, cw_cnt;
    bit exp_nwr, exp_cwr, seen;
    logic [W-1:0] g_id, g_h, g_c, g_e, g_q, g_cd;
    int g_na, g_ca;
    n0 = m_ncnt; m0 = m_ccnt;
    exp_nwr = 0; exp_cwr = 0; exp_naddr = 0; exp_caddr = 0;
    if (id == '0) begin
      exp_res = 3;
    end else begin
      found = -1;
      for (int i = 0; i < m_ncnt; i++) if (found < 0 && m_id[i] == id) found = i;
      if (found >= 0) begin
        exp_res = 0; exp_nwr = 1; exp_naddr = found;
      end else if (m_ncnt < MN) begin
        exp_res = 1; exp_nwr = 1; exp_naddr = m_ncnt; m_ncnt++;
      end else begin
        mi = 0;
        for (int i = 1; i < MN; i++) if (m_q[i] < m_q[mi]) mi = i;
        if (q > m_q[mi]) begin exp_res = 2; exp_nwr = 1; exp_naddr = mi; end
        else exp_res = 3;
      end
      if (exp_nwr) begin m_id[exp_naddr] = id; m_q[exp_naddr] = q; end
      if (ch != '0) begin
        seen = 0;
        for (int i = 0; i < m_ccnt; i++) if (m_ch[i] == ch) seen = 1;
        if (!seen && m_ccnt < MC) begin
          exp_cwr = 1; exp_caddr = m_ccnt; m_ch[m_ccnt] = ch; m_ccnt++;
        end
      end
    end

    @(negedge clk);
    f_src_id = id; f_src_hops = hops; f_cluster_id = cl; f_energy = e;
    f_qvalue = q; f_known_ch = ch; f_pkt_type = 3'b101; en = 1'b1;
    lat = 0; nw_cnt = 0; cw_cnt = 0; nw_j = 0; cw_j = 0;
    g_id = '0; g_h = '0; g_c = '0; g_e = '0; g_q = '0; g_cd = '0; g_na = 0; g_ca = 0;
    for (int j = 1; j <= 64 && lat == 0; j++) begin
      @(negedge clk);
      en = poke && (j == 1);
      if (poke && j == 1) begin
        f_src_id = id ^ 16'h0040; f_qvalue = ~q; f_known_ch = ch + 16'd7; f_energy = ~e;
      end
      if (j == 1) check("busy_after_en", busy, 1);
      if (nbr_wr_en) begin
        nw_cnt++; nw_j = j; g_na = nbr_wr_addr; g_id = nbr_wr_id; g_h = nbr_wr_hops;
        g_c = nbr_wr_cluster; g_e = nbr_wr_energy; g_q = nbr_wr_q;
      end
      if (ch_wr_en) begin cw_cnt++; cw_j = j; g_ca = ch_wr_addr; g_cd = ch_wr_data; end
      if (done) lat = j;
    end
    en = 1'b0;
    check("done_seen", lat != 0, 1);
    if (exp_lat != 0) check("done_latency", lat, exp_lat);
    else check("latency_bound", (lat > 0) && (lat <= n0 + m0 + 7), 1);
    check("result", result, exp_res);
    check("nbr_wr_strobes", nw_cnt, exp_nwr);
    if (exp_nwr) begin
      check("nbr_wr_addr", g_na, exp_naddr);
      check("nbr_wr_id", g_id, id);
      check("nbr_wr_hops", g_h, hops);
      check("nbr_wr_cluster", g_c, cl);
      check("nbr_wr_energy", g_e, e);
      check("nbr_wr_q", g_q, q);
    end
    check("ch_wr_strobes", cw_cnt, exp_cwr);
    if (exp_cwr) begin
      check("ch_wr_addr", g_ca, exp_caddr);
      check("ch_wr_data", g_cd, ch);
    end
    check("neighbor_count", neighbor_count, m_ncnt);
    check("known_ch_count", known_ch_count, m_ccnt);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int nj, cj, dcnt;
    for (int i = 0; i < MN; i++) begin mem_id[i] = '0; mem_q[i] = '0; end
    for (int i = 0; i < MC; i++) mem_ch[i] = '0;
    m_ncnt = 0; m_ccnt = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    f_src_id = '0; f_src_hops = '0; f_cluster_id = '0; f_energy = '0;
    f_qvalue = '0; f_known_ch = '0; f_pkt_type = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_nbr_count", neighbor_count, 0);
    check("rst_ch_count", known_ch_count, 0);
    check("rst_nbr_wr_en", nbr_wr_en, 0);

    // Empty tables: write k+1, CH write k+2, done k+3.
    run_pkt(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15, 1'b0, 3, nj, cj);
    check("empty_nbr_wr_cycle", nj, 1);
    check("empty_ch_wr_cycle", cj, 2);
    check("empty_result", result, 1);
    run_pkt(16'd17, 16'd3, 16'd2, 16'h1234, 16'hB800, 16'd15, 1'b0, 0, nj, cj);
    run_pkt(16'd1, 16'd2, 16'd2, 16'h8000, 16'h1000, 16'd15, 1'b0, 0, nj, cj);
    check("update_result", result, 0);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_ncnt = 0; m_ccnt = 0;
    check("clr_nbr_count", neighbor_count, 0);
    check("clr_ch_count", known_ch_count, 0);

    run_pkt(16'd1, 16'd1, 16'd1, 16'h0100, 16'h3000, 16'd0, 1'b0, 0, nj, cj);
    run_pkt(16'd2, 16'd1, 16'd1, 16'h0200, 16'h1000, 16'd0, 1'b0, 0, nj, cj);
    run_pkt(16'd3, 16'd1, 16'd1, 16'h0300, 16'h1000, 16'd0, 1'b0, 0, nj, cj);
    run_pkt(16'd4, 16'd1, 16'd1, 16'h0400, 16'h5000, 16'd0, 1'b0, 0, nj, cj);
    run_pkt(16'd9, 16'd2, 16'd5, 16'h0900, 16'h2000, 16'd0, 1'b0, 0, nj, cj);
    check("replace_result", result, 2);
    run_pkt(16'd10, 16'd2, 16'd5, 16'h0A00, 16'h0800, 16'd0, 1'b0, 0, nj, cj);
    check("drop_result", result, 3);

    // en while busy must be ignored and later field changes must not leak in.
    run_pkt(16'd3, 16'd4, 16'd6, 16'h0333, 16'h7777, 16'd2, 1'b1, 0, nj, cj);
    dcnt = 0;
    for (int j = 0; j < 8; j++) begin @(negedge clk); if (done) dcnt++; end
    check("busy_en_ignored", dcnt, 0);

    // Reset in the middle of a neighbour scan.
    @(negedge clk);
    f_src_id = 16'd4; f_qvalue = 16'h4444; f_known_ch = 16'd2; en = 1'b1;
    @(negedge clk); en = 1'b0;
    check("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midop_rst_busy", busy, 0);
    check("midop_rst_nbr_count", neighbor_count, 0);
    check("midop_rst_ch_count", known_ch_count, 0);
    check("midop_rst_rd_addr", nbr_rd_addr, 0);
    check("midop_rst_result", result, 0);
    m_ncnt = 0; m_ccnt = 0;
    @(negedge clk); rst_n = 1'b1;

    run_pkt(16'd5, 16'd1, 16'd1, 16'h0500, 16'h0500, 16'd3, 1'b0, 3, nj, cj);
    @(negedge clk);
    clr = 1'b1; en = 1'b1; f_src_id = 16'd6; f_known_ch = 16'd4;
    @(negedge clk);
    clr = 1'b0; en = 1'b0;
    check("clr_en_busy", busy, 0);
    dcnt = 0;
    for (int j = 0; j < 8; j++) begin @(negedge clk); if (done) dcnt++; end
    check("clr_en_no_done", dcnt, 0);
    check("clr_en_nbr_count", neighbor_count, 0);
    check("clr_en_ch_count", known_ch_count, 0);
    m_ncnt = 0; m_ccnt = 0;

    run_pkt(16'd0, 16'd1, 16'd1, 16'h0001, 16'hFFFF, 16'd9, 1'b0, 2, nj, cj);

    for (int t = 0; t < 40; t++) begin
      run_pkt(W'($urandom_range(0, 6)), W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), W'($urandom_range(0, 5)), 1'b0, 0, nj, cj);
    end
    for (int i = 0; i < m_ncnt; i++) begin
      check("final_ram_id", mem_id[i], m_id[i]);
      check("final_ram_q", mem_q[i], m_q[i]);
    end
    for (int i = 0; i < m_ccnt; i++) check("final_ram_ch", mem_ch[i], m_ch[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
